uart_tx_arbiter: RTL and testbench

- Shares one UART transmit line between NUM_REQ byte requesters using round-robin arbitration, one whole frame per grant.
- Serializes each granted byte as an 8N1 frame: start bit, data LSB first, one stop bit.
- Bit timing comes from the level-type tx baud clock produced by the baud rate generator. That clock toggles at half-bit intervals, and its rising edge marks a bit boundary.
- Sits between the host-side request sources and the tx pin.

---
 rtl/uart_tx_arbiter.sv | 127 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART tx line, one 8N1 frame per grant.
// Define UART_TX_ARB_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tx_clk,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [ID_WIDTH-1:0]           grant_id
);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

`ifdef UART_TX_ARB_PARITY_EN
    typedef enum logic [2:0] {IDLE, WAIT_TICK, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, WAIT_TICK, START, DATA, STOP} state_t;
`endif

    state_t                state;
    logic                  tx_clk_q;
    logic                  tick;
    logic                  any_valid;
    logic [DATA_WIDTH-1:0] shift;
    logic [CW-1:0]         bit_cnt;
    logic [ID_WIDTH-1:0]   last_grant;
    logic [ID_WIDTH-1:0]   winner;
    logic [ID_WIDTH-1:0]   idx;
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
`ifdef UART_TX_ARB_PARITY_EN
    logic                  par;
`endif

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign any_valid = |req_valid;
    assign tick      = tx_clk & ~tx_clk_q;
    assign req_ready = (state == IDLE && !reset && any_valid) ? NUM_REQ'(1) << winner : '0;

    // Pick the first valid requester after last_grant, wrapping around.
    always_comb begin
        winner = last_grant;
        idx    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = ID_WIDTH'((int'(last_grant) + k) % NUM_REQ);
            if (req_valid[idx]) winner = idx;
        end
    end

    // Baud clock level delayed one cycle for rising-edge detection.
    always_ff @(posedge clk) begin
        tx_clk_q <= reset ? 1'b0 : tx_clk;
    end

    // Frame state machine: accept in IDLE, then shift start/data/stop on ticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            grant_id   <= '0;
            last_grant <= ID_WIDTH'(NUM_REQ - 1);
            bit_cnt    <= '0;
            shift      <= '0;
`ifdef UART_TX_ARB_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (any_valid) begin
                    shift      <= data_arr[winner];
                    grant_id   <= winner;
                    last_grant <= winner;
                    busy       <= 1'b1;
                    state      <= WAIT_TICK;
`ifdef UART_TX_ARB_PARITY_EN
                    par        <= ^data_arr[winner];
`endif
                end
                WAIT_TICK: if (tick) begin
                    tx    <= 1'b0;
                    state <= START;
                end
                START: if (tick) begin
                    tx      <= shift[0];
                    shift   <= shift >> 1;
                    bit_cnt <= '0;
                    state   <= DATA;
                end
                DATA: if (tick) begin
                    if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_ARB_PARITY_EN
                        tx    <= par;
                        state <= PARITY;
`else
                        tx    <= 1'b1;
                        state <= STOP;
`endif
                    end else begin
                        tx      <= shift[0];
                        shift   <= shift >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_ARB_PARITY_EN
                PARITY: if (tick) begin
                    tx    <= 1'b1;
                    state <= STOP;
                end
`endif
                STOP: if (tick) begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table vectors, hand sequences and randomized traffic against a frame-level model.
module tb_uart_tx_arbiter;
`ifdef UART_TX_ARB_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB = 10 + PAR;

    logic        clk, reset, tx_clk, tx, busy;
    logic [3:0]  req_valid, req_ready;
    logic [31:0] req_data;
    logic [1:0]  grant_id;
    logic        txclk_pos;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q [$];

    uart_tx_arbiter dut (
        .clk(clk), .reset(reset), .tx_clk(tx_clk),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .tx(tx), .busy(busy), .grant_id(grant_id)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        tx_clk = 0;
        forever begin
            repeat (8) @(negedge clk);
            tx_clk = ~tx_clk;
        end
    end

    always @(posedge clk) txclk_pos <= tx_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] v, input int last);
        for (int k = 1; k <= 4; k++) if (v[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    // Line monitor: decodes frames at bit centres and compares with the expected byte queue.
    bit mon_en = 0;
    bit mon_busy = 0;
    int mon_cnt = 0;
    logic [7:0] mon_byte, mon_e;
    logic mon_par;
    always @(negedge clk) begin
        if (reset || !mon_en) mon_busy = 0;
        else if (!mon_busy) begin
            if (tx === 1'b0) begin
                mon_busy = 1;
                mon_cnt = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % 16 == 8) begin
                if (mon_cnt / 16 == 0) chk("mon start bit", tx, 0);
                else if (mon_cnt / 16 <= 8) mon_byte = {tx, mon_byte[7:1]};
`ifdef UART_TX_ARB_PARITY_EN
                else if (mon_cnt / 16 == 9) mon_par = tx;
`endif
                else begin
                    chk("mon stop bit", tx, 1);
                    chk("mon frame pending", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        mon_e = exp_q.pop_front();
                        chk("mon frame byte", mon_byte, mon_e);
`ifdef UART_TX_ARB_PARITY_EN
                        chk("mon parity", mon_par, ^mon_e);
`endif
                    end
                    mon_busy = 0;
                end
            end
        end
    end

    // Present a request, wait for its grant, check it and release valid after the accept.
    task automatic serve(input logic [3:0] m, input logic [31:0] d, input int id,
                         input logic [7:0] b, input string nm);
        int n = 0;
        req_valid = m;
        req_data = d;
        #1;
        while (req_ready == 4'b0 && n < 600) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({nm, " ready"}, req_ready, 32'(1) << id);
        exp_q.push_back(b);
        @(negedge clk);
        chk({nm, " ready pulse"}, req_ready, 0);
        req_valid = 0;
        chk({nm, " grant_id"}, grant_id, id);
        chk({nm, " busy"}, busy, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy !== 1'b0 || mon_busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("idle reached", n < 1000, 1);
    endtask

    task automatic wait_fall(output int n);
        n = 0;
        while (tx !== 1'b0 && n < 64) begin
            @(negedge clk);
            n++;
        end
    endtask

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] data;
        int          id;
        logic [7:0]  exp_byte;
    } vec_t;
    vec_t tab [11];

    logic [0:191] s_tx, s_busy;
    logic [10:0]  bits;
    logic [15:0]  vec;
    int n, k, bad, acc, cyc, pend, w, model_last, max_wait;
    int wait_cnt [4];

    initial begin
        tab[0]  = '{4'b1111, 32'h13121110, 0, 8'h10};
        tab[1]  = '{4'b1111, 32'h13121110, 1, 8'h11};
        tab[2]  = '{4'b1111, 32'h13121110, 2, 8'h12};
        tab[3]  = '{4'b1111, 32'h13121110, 3, 8'h13};
        tab[4]  = '{4'b1111, 32'h13121110, 0, 8'h10};
        tab[5]  = '{4'b0100, 32'h00070000, 2, 8'h07};
        tab[6]  = '{4'b0110, 32'h0055AA00, 1, 8'hAA};
        tab[7]  = '{4'b0011, 32'h00003CC3, 0, 8'hC3};
        tab[8]  = '{4'b1001, 32'hFF000001, 3, 8'hFF};
        tab[9]  = '{4'b1000, 32'h80000000, 3, 8'h80};
        tab[10] = '{4'b0101, 32'h005A00E7, 0, 8'hE7};

        reset = 1;
        req_valid = 0;
        req_data = 0;
        repeat (3) @(negedge clk);
        chk("reset tx", tx, 1);
        chk("reset busy", busy, 0);
        chk("reset grant_id", grant_id, 0);
        chk("reset ready", req_ready, 0);
        req_valid = 4'b0001;
        #1;
        chk("ready gated in reset", req_ready, 0);
        req_valid = 0;
        @(negedge clk);
        reset = 0;
        mon_en = 1;

        // Single 0xA5 frame: exact waveform, 16 clk per bit.
        serve(4'b0001, 32'h000000A5, 0, 8'hA5, "a5");
        wait_fall(n);
        chk("a5 start seen", tx, 0);
`ifdef UART_TX_ARB_PARITY_EN
        bits = {1'b1, ^8'hA5, 8'hA5, 1'b0};
`else
        bits = {1'b1, 1'b1, 8'hA5, 1'b0};
`endif
        for (int c = 0; c <= NB * 16; c++) begin
            s_tx[c] = tx;
            s_busy[c] = busy;
            if (c < NB * 16) @(negedge clk);
        end
        for (int b = 0; b < NB; b++) begin
            for (int j = 0; j < 16; j++) vec[j] = s_tx[b*16 + j];
            chk($sformatf("a5 bit%0d", b), vec, bits[b] ? 16'hFFFF : 16'h0000);
        end
        chk("a5 busy last stop cycle", s_busy[NB*16 - 1], 1);
        chk("a5 busy after stop tick", s_busy[NB*16], 0);
        chk("a5 tx idle after frame", s_tx[NB*16], 1);

        // Tick phase: accept on the tick edge, then one cycle after a tick.
        wait_idle();
        @(negedge clk);
        #1;
        n = 0;
        while (!(tx_clk && !txclk_pos) && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        serve(4'b0001, 32'h0000005E, 0, 8'h5E, "lat on-tick");
        k = 1;
        while (tx !== 1'b0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("lat accept on tick", k - 1, 16);
        wait_idle();
        @(negedge clk);
        #1;
        n = 0;
        while (!(tx_clk && !txclk_pos) && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        #1;
        serve(4'b0001, 32'h0000006A, 0, 8'h6A, "lat after-tick");
        k = 1;
        while (tx !== 1'b0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("lat accept after tick", k - 1, 15);

        // Reset during data bit 3 abandons the frame and restores last_grant.
        wait_idle();
        serve(4'b0001, 32'h000000C3, 0, 8'hC3, "abort");
        wait_fall(n);
        repeat (70) @(negedge clk);
        chk("abort bit3 before reset", tx, 0);
        mon_en = 0;
        reset = 1;
        @(negedge clk);
        chk("abort tx", tx, 1);
        chk("abort busy", busy, 0);
        chk("abort grant_id", grant_id, 0);
        exp_q.delete();
        req_valid = 4'b0011;
        req_data = 32'h00005A3C;
        #1;
        chk("abort ready in reset", req_ready, 0);
        @(negedge clk);
        reset = 0;
        mon_en = 1;
        serve(4'b0011, 32'h00005A3C, 0, 8'h3C, "post-reset");

        // Table vectors from a fresh reset.
        wait_idle();
        reset = 1;
        @(negedge clk);
        reset = 0;
        for (int r = 0; r < 11; r++)
            serve(tab[r].mask, tab[r].data, tab[r].id, tab[r].exp_byte, $sformatf("tab%0d", r));

        // Fairness and withdrawal.
        serve(4'b0100, 32'h00210000, 2, 8'h21, "fair first");
        req_valid = 4'b0100;
        req_data = 32'h00220000;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (req_ready != 0) bad++;
        end
        req_valid[1] = 1'b1;
        req_data[15:8] = 8'h99;
        repeat (100) begin
            @(negedge clk);
            #1;
            if (req_ready != 0) bad++;
        end
        req_valid[1] = 1'b0;
        chk("fair no ready while busy", bad, 0);
        serve(4'b0100, 32'h00220000, 2, 8'h22, "fair regrant");
        serve(4'b0110, 32'h00324200, 1, 8'h42, "fair after 2");

        // Randomized traffic against the round-robin model.
        wait_idle();
        reset = 1;
        @(negedge clk);
        reset = 0;
        model_last = 3;
        acc = 0;
        cyc = 0;
        pend = -1;
        max_wait = 0;
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        while (acc < 40 && cyc < 15000) begin
            @(negedge clk);
            cyc++;
            if (pend >= 0) begin
                req_valid[pend] = 1'b0;
                chk("rnd grant_id", grant_id, pend);
                chk("rnd busy", busy, 1);
                pend = -1;
            end
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 9) == 0) begin
                        req_valid[i] = 1'b1;
                        req_data[i*8 +: 8] = 8'($urandom);
                    end
                end else if ($urandom_range(0, 199) == 0) req_valid[i] = 1'b0;
                wait_cnt[i] = req_valid[i] ? wait_cnt[i] + 1 : 0;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end
            #1;
            if (req_ready != 0) begin
                w = rr_pick(req_valid, model_last);
                chk("rnd ready", req_ready, w < 0 ? 0 : 32'(1) << w);
                chk("rnd line idle at accept", exp_q.size(), 0);
                if (w >= 0) begin
                    exp_q.push_back(req_data[w*8 +: 8]);
                    model_last = w;
                    pend = w;
                end
                acc++;
            end
        end
        chk("rnd accepts reached", acc >= 40, 1);
        chk("rnd wait bounded", max_wait > 1000, 0);
        @(negedge clk);
        req_valid = 0;
        wait_idle();
        chk("rnd queue drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
